// File: rtl/dbus_store_buffer_pkg.sv
// dbus_store_buffer_pkg: shared bus types, store-buffer entry and FSM state encoding.
package dbus_store_buffer_pkg;
    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [3:0]  strobe_t;
    typedef logic [2:0]  msize_t;

    typedef struct packed {
        addr_t   addr;
        msize_t  size;
        word_t   wd;
        strobe_t strobe;
    } sb_entry_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        LD_ADDR = 3'd3,
        LD_DATA = 3'd4
    } sb_state_t;
endpackage

// File: rtl/dbus_store_buffer_fifo.sv
// sb_fifo: small circular store queue; full is based on the registered count only,
// so a same-cycle pop never frees a slot for a push.
module sb_fifo
    import dbus_store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  logic      pop,
    input  sb_entry_t din,
    output sb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign head    = mem_q[head_q];
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= pop  ? head_q + 1'b1 : head_q;
            tail_q  <= push ? tail_q + 1'b1 : tail_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= din;
    end
endmodule

// File: rtl/dbus_store_buffer.sv
// dbus_store_buffer: queues aligned stores and drains them to the data bus one
// transaction at a time; loads issue only once every earlier store has committed.
module dbus_store_buffer
    import dbus_store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    in_valid,
    input  logic    in_is_store,
    input  addr_t   in_addr,
    input  msize_t  in_size,
    input  word_t   in_wd,
    input  strobe_t in_strobe,
    output logic    in_ready,
    output word_t   load_data,
    output logic    dreq_valid,
    output addr_t   dreq_addr,
    output msize_t  dreq_size,
    output strobe_t dreq_strobe,
    output word_t   dreq_data,
    input  logic    dresp_addr_ok,
    input  logic    dresp_data_ok,
    input  word_t   dresp_data
);
    sb_state_t state_q, state_d;
    sb_entry_t head;
    logic      full, empty, push, pop, ld_req, ld_done;

    assign ld_req = in_valid & ~in_is_store;
    assign push   = in_valid & in_is_store & ~full;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    ('{addr: in_addr, size: in_size, wd: in_wd, strobe: in_strobe}),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // data_ok without a prior addr_ok is a protocol error and is ignored in the *_ADDR states
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ld_done     = 1'b0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_strobe = '0;
        dreq_data   = '0;
        case (state_q)
            IDLE:    state_d = (!empty || push) ? ST_ADDR : ld_req ? LD_ADDR : IDLE;
            ST_ADDR: begin
                dreq_valid  = 1'b1;
                dreq_addr   = head.addr;
                dreq_size   = head.size;
                dreq_strobe = head.strobe;
                dreq_data   = head.wd;
                pop         = dresp_addr_ok & dresp_data_ok;
                state_d     = !dresp_addr_ok ? ST_ADDR : dresp_data_ok ? IDLE : ST_DATA;
            end
            ST_DATA: begin
                pop     = dresp_data_ok;
                state_d = dresp_data_ok ? IDLE : ST_DATA;
            end
            LD_ADDR: begin
                dreq_valid = 1'b1;
                dreq_addr  = in_addr;
                dreq_size  = in_size;
                ld_done    = dresp_addr_ok & dresp_data_ok;
                state_d    = !dresp_addr_ok ? LD_ADDR : dresp_data_ok ? IDLE : LD_DATA;
            end
            LD_DATA: begin
                ld_done = dresp_data_ok;
                state_d = dresp_data_ok ? IDLE : LD_DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // a load abandoned by upstream still completes on the bus but produces no in_ready
    assign in_ready  = push | (ld_done & ld_req);
    assign load_data = (ld_done & ld_req) ? dresp_data : '0;
endmodule

// File: tb/tb_dbus_store_buffer.sv
// tb_dbus_store_buffer: directed scenario tests for dbus_store_buffer with DEPTH=2.
module tb_dbus_store_buffer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_is_store;
    logic [31:0] in_addr, in_wd;
    logic [2:0]  in_size;
    logic [3:0]  in_strobe;
    logic        in_ready;
    logic [31:0] load_data;
    logic        dreq_valid;
    logic [31:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dbus_store_buffer #(.DEPTH(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_is_store   (in_is_store),
        .in_addr       (in_addr),
        .in_size       (in_size),
        .in_wd         (in_wd),
        .in_strobe     (in_strobe),
        .in_ready      (in_ready),
        .load_data     (load_data),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_valid = 0; in_is_store = 0; in_addr = 0; in_size = 0; in_wd = 0; in_strobe = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        in_valid = 1; in_is_store = 1; in_addr = a; in_wd = d; in_strobe = s; in_size = 3'd2;
    endtask

    task automatic test_reset();
        quiet();
        resetn = 0;
        #1;
        tests++;
        if ({in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, load_data} !== '0) begin
            fails++; $display("FAIL reset_init: outputs=%h required 0", {in_ready, dreq_valid, dreq_addr, dreq_data, load_data});
        end
        tick(); tick();
        resetn = 1;
        tick();
        store(32'h200, 32'h11, 4'hf);
        tick();
        in_valid = 0;
        dresp_addr_ok = 1;
        tick();
        dresp_addr_ok = 0;
        #2 resetn = 0;
        #1;
        tests++;
        if ({in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, load_data} !== '0) begin
            fails++; $display("FAIL reset_mid_st_data: outputs=%h required 0", {in_ready, dreq_valid, dreq_addr, dreq_data, load_data});
        end
        tick();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (dreq_valid !== 1'b0) begin
                fails++; $display("FAIL reset_idle_%0d: dreq_valid=%b required 0", i, dreq_valid);
            end
            tick();
        end
    endtask

    task automatic test_single_store();
        store(32'h8000_0004, 32'h0000_AB00, 4'b0010);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || dreq_valid !== 1'b0) begin
            fails++; $display("FAIL single_c0: in_ready=%b dreq_valid=%b required 1 0", in_ready, dreq_valid);
        end
        tick();
        in_valid = 0;
        @(negedge clk);
        tests++;
        if ({dreq_valid, dreq_addr, dreq_data, dreq_strobe, dreq_size} !== {1'b1, 32'h8000_0004, 32'h0000_AB00, 4'b0010, 3'd2}) begin
            fails++; $display("FAIL single_c1: v=%b a=%h d=%h s=%b z=%0d required 1 80000004 0000ab00 0010 2",
                              dreq_valid, dreq_addr, dreq_data, dreq_strobe, dreq_size);
        end
        tick();
        dresp_addr_ok = 1;
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h8000_0004) begin
            fails++; $display("FAIL single_c2_hold: v=%b a=%h required 1 80000004", dreq_valid, dreq_addr);
        end
        tick();
        dresp_addr_ok = 0;
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0) begin
            fails++; $display("FAIL single_c3_st_data: dreq_valid=%b required 0", dreq_valid);
        end
        tick();
        dresp_data_ok = 1;
        tick();
        dresp_data_ok = 0;
        tick();
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0) begin
            fails++; $display("FAIL single_empty: dreq_valid=%b required 0", dreq_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        store(32'h10, 32'hA1, 4'hf);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_st1: in_ready=%b required 1", in_ready); end
        tick();
        store(32'h20, 32'hA2, 4'hf);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_st2: in_ready=%b required 1", in_ready); end
        tick();
        store(32'h30, 32'hA3, 4'hf);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || dreq_addr !== 32'h10 || dreq_valid !== 1'b1) begin
                fails++; $display("FAIL b2b_full_%0d: in_ready=%b addr=%h required 0 00000010", i, in_ready, dreq_addr);
            end
            tick();
        end
        dresp_addr_ok = 1;
        tick();
        dresp_addr_ok = 0;
        dresp_data_ok = 1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_no_bypass: in_ready=%b required 0", in_ready); end
        tick();
        dresp_data_ok = 0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_st3_accept: in_ready=%b required 1", in_ready); end
        tick();
        in_valid = 0;
        dresp_addr_ok = 1; dresp_data_ok = 1;
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h20 || dreq_data !== 32'hA2) begin
            fails++; $display("FAIL b2b_order2: v=%b a=%h d=%h required 1 00000020 000000a2", dreq_valid, dreq_addr, dreq_data);
        end
        tick();
        tick();
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h30 || dreq_data !== 32'hA3) begin
            fails++; $display("FAIL b2b_order3: v=%b a=%h d=%h required 1 00000030 000000a3", dreq_valid, dreq_addr, dreq_data);
        end
        tick();
        dresp_addr_ok = 0; dresp_data_ok = 0;
        tick();
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: dreq_valid=%b required 0", dreq_valid); end
        tick();
    endtask

    task automatic test_load_behind_store();
        store(32'h100, 32'hDEAD_BEEF, 4'hf);
        tick();
        in_is_store = 0; in_wd = 0; in_strobe = 0;
        dresp_addr_ok = 1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || dreq_strobe !== 4'hf || dreq_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL lbs_store_first: rdy=%b s=%h d=%h required 0 f deadbeef", in_ready, dreq_strobe, dreq_data);
        end
        tick();
        dresp_addr_ok = 0;
        dresp_data_ok = 1;
        tick();
        dresp_data_ok = 0;
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL lbs_wait: v=%b rdy=%b required 0 0", dreq_valid, in_ready);
        end
        tick();
        dresp_addr_ok = 1;
        @(negedge clk);
        tests++;
        if ({dreq_valid, dreq_addr, dreq_strobe, dreq_data, in_ready} !== {1'b1, 32'h100, 4'h0, 32'h0, 1'b0}) begin
            fails++; $display("FAIL lbs_ld_req: v=%b a=%h s=%h d=%h rdy=%b required 1 00000100 0 0 0",
                              dreq_valid, dreq_addr, dreq_strobe, dreq_data, in_ready);
        end
        tick();
        dresp_addr_ok = 0;
        dresp_data_ok = 1; dresp_data = 32'h1234_5678;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || load_data !== 32'h1234_5678) begin
            fails++; $display("FAIL lbs_ld_done: rdy=%b data=%h required 1 12345678", in_ready, load_data);
        end
        tick();
        quiet();
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || load_data !== 32'h0 || dreq_valid !== 1'b0) begin
            fails++; $display("FAIL lbs_one_cycle: rdy=%b data=%h v=%b required 0 0 0", in_ready, load_data, dreq_valid);
        end
        tick();
    endtask

    task automatic test_combined();
        store(32'h400, 32'h55, 4'h1);
        tick();
        in_valid = 0;
        dresp_addr_ok = 1; dresp_data_ok = 1;
        tick();
        dresp_addr_ok = 0; dresp_data_ok = 0;
        in_valid = 1; in_is_store = 0; in_addr = 32'h404;
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL comb_store_done: v=%b rdy=%b required 0 0", dreq_valid, in_ready);
        end
        tick();
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'hCAFE_F00D;
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h404 || in_ready !== 1'b1 || load_data !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL comb_load: v=%b a=%h rdy=%b data=%h required 1 00000404 1 cafef00d",
                              dreq_valid, dreq_addr, in_ready, load_data);
        end
        tick();
        quiet();
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL comb_after: v=%b rdy=%b required 0 0", dreq_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_push_while_pop();
        store(32'h500, 32'hB0, 4'hf);
        tick();
        in_valid = 0;
        dresp_addr_ok = 1;
        tick();
        dresp_addr_ok = 0;
        dresp_data_ok = 1;
        store(32'h504, 32'hB1, 4'hf);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL pwp_push: in_ready=%b required 1", in_ready); end
        tick();
        dresp_data_ok = 0;
        store(32'h508, 32'hB2, 4'hf);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL pwp_count_one: in_ready=%b required 1", in_ready); end
        tick();
        store(32'h50C, 32'hB3, 4'hf);
        dresp_addr_ok = 1; dresp_data_ok = 1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || dreq_addr !== 32'h504 || dreq_data !== 32'hB1) begin
            fails++; $display("FAIL pwp_next_issue: rdy=%b a=%h d=%h required 0 00000504 000000b1", in_ready, dreq_addr, dreq_data);
        end
        tick();
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL pwp_refill: in_ready=%b required 1", in_ready); end
        tick();
        in_valid = 0;
        @(negedge clk);
        tests++;
        if (dreq_addr !== 32'h508) begin fails++; $display("FAIL pwp_order_b2: addr=%h required 00000508", dreq_addr); end
        tick();
        tick();
        @(negedge clk);
        tests++;
        if (dreq_addr !== 32'h50C) begin fails++; $display("FAIL pwp_order_b3: addr=%h required 0000050c", dreq_addr); end
        tick();
        quiet();
        tick();
        @(negedge clk);
        tests++;
        if (dreq_valid !== 1'b0) begin fails++; $display("FAIL pwp_drained: dreq_valid=%b required 0", dreq_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_back_to_back();
        test_load_behind_store();
        test_combined();
        test_push_while_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
